// File: rtl/gear_pkg.sv
// Shared definitions for the 20-bit slice datapath behind the 32->20 gearbox.
package gear_pkg;
  localparam int SLICE_W    = 20;
  localparam int SLICES_DEF = 5;
  localparam int WIDTH_DEF  = 96;

  typedef logic [SLICE_W-1:0] slice_t;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    DROP = 1'b1
  } frame_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/hit_fifo.sv
// Small synchronous tag FIFO; a push into a full FIFO succeeds only when a pop happens in the same cycle.
module hit_fifo #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [TAG_W-1:0] din,
  output logic [TAG_W-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [TAG_W-1:0] mem_d [DEPTH];
  logic [PTR_W:0]   wr_q, wr_d, rd_q, rd_d;
  logic             do_push_s, do_pop_s;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign dout  = empty ? {TAG_W{1'b0}} : mem_q[rd_q[PTR_W-1:0]];

  // Pointer and storage update.
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    mem_d     = mem_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    if (do_push_s) begin
      mem_d[wr_q[PTR_W-1:0]] = din;
      wr_d = wr_q + PTR_ONE;
    end else begin
      wr_d = wr_q;
    end
    if (do_pop_s) begin
      rd_d = rd_q + PTR_ONE;
    end else begin
      rd_d = rd_q;
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {TAG_W{1'b0}};
      end
      wr_q <= {(PTR_W+1){1'b0}};
      rd_q <= {(PTR_W+1){1'b0}};
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end
endmodule

// File: rtl/digest_match20.sv
// Reassembles 20-bit digest slices, compares them against a masked target and
// queues the tags of matching digests for the controller.
module digest_match20
  import gear_pkg::*;
#(
  parameter int SLICES = SLICES_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int TAG_W  = 32,
  parameter int DEPTH  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  slice_t           in_data,
  input  logic             in_last,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] target_mask,
  input  logic             clear,
  output logic             hit_valid,
  output logic [TAG_W-1:0] hit_tag,
  input  logic             hit_ready,
  output logic [31:0]      hit_count,
  output logic             err_frame,
  output logic             err_ovf
);
  localparam int ACC_W = SLICES * SLICE_W;
  localparam int CNT_W = $clog2(SLICES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLICES - 1);

  frame_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             done_q, done_d;
  logic             frame_err_s;
  logic             cmp_valid_q, cmp_valid_d;
  logic             cmp_match_q, cmp_match_d;
  logic [TAG_W-1:0] cmp_tag_q, cmp_tag_d;
  logic [31:0]      hit_count_q, hit_count_d;
  logic             err_frame_q, err_frame_d;
  logic             err_ovf_q, err_ovf_d;
  logic             push_s, ovf_s, full_s, empty_s;
  logic             unused_acc_hi_s;

  // The carried bits above WIDTH exist only because slices are 20 bits wide.
  assign unused_acc_hi_s = ^acc_q[ACC_W-1:WIDTH];

  function automatic logic masked_eq(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] m);
    return ((a ^ b) & m) == {WIDTH{1'b0}};
  endfunction

  // Frame assembly: slice placement, tag capture and framing-error detection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    tag_d       = tag_q;
    done_d      = 1'b0;
    frame_err_s = 1'b0;
    case (state_q)
      RUN: begin
        if (in_valid) begin
          acc_d[cnt_q*SLICE_W +: SLICE_W] = in_data;
          tag_d = (cnt_q == CNT_ZERO) ? in_tag : tag_q;
          if (in_last) begin
            cnt_d       = CNT_ZERO;
            done_d      = (cnt_q == CNT_LAST);
            frame_err_s = (cnt_q != CNT_LAST);
          end else if (cnt_q == CNT_LAST) begin
            cnt_d       = CNT_ZERO;
            frame_err_s = 1'b1;
            state_d     = DROP;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      DROP: begin
        if (in_valid && in_last) begin
          state_d = RUN;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  assign push_s = cmp_valid_q && cmp_match_q;
  // Full implies non-empty, so a ready pop always frees a slot for this push.
  assign ovf_s  = push_s && full_s && !hit_ready;

  // Compare stage, hit counter and sticky flags; a set event wins over clear.
  always_comb begin
    cmp_valid_d = done_q;
    cmp_match_d = masked_eq(acc_q[WIDTH-1:0], target, target_mask);
    cmp_tag_d   = done_q ? tag_q : cmp_tag_q;
    hit_count_d = clear ? 32'd0 : hit_count_q;
    hit_count_d = push_s ? sat_inc32(hit_count_d) : hit_count_d;
    err_frame_d = frame_err_s || (err_frame_q && !clear);
    err_ovf_d   = ovf_s || (err_ovf_q && !clear);
  end

  // Pipeline and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= CNT_ZERO;
      acc_q       <= {ACC_W{1'b0}};
      tag_q       <= {TAG_W{1'b0}};
      done_q      <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_match_q <= 1'b0;
      cmp_tag_q   <= {TAG_W{1'b0}};
      hit_count_q <= 32'd0;
      err_frame_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      tag_q       <= tag_d;
      done_q      <= done_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_match_q <= cmp_match_d;
      cmp_tag_q   <= cmp_tag_d;
      hit_count_q <= hit_count_d;
      err_frame_q <= err_frame_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  hit_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_hit_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (hit_ready),
    .din   (cmp_tag_q),
    .dout  (hit_tag),
    .full  (full_s),
    .empty (empty_s)
  );

  assign hit_valid = !empty_s;
  assign hit_count = hit_count_q;
  assign err_frame = err_frame_q;
  assign err_ovf   = err_ovf_q;
endmodule

// File: tb/tb_digest_match20.sv
// Bench for digest_match20: vector table, corner sequences and random traffic
// checked every cycle against a queue-based transaction model.
module tb_digest_match20;
  localparam int SLICES = 5;
  localparam int WIDTH  = 96;
  localparam int TAG_W  = 32;
  localparam int DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_last, clear, hit_ready;
  logic [19:0] in_data;
  logic [31:0] in_tag, hit_tag, hit_count;
  logic [95:0] target, target_mask;
  logic        hit_valid, err_frame, err_ovf;

  always #5 clk = ~clk;

  digest_match20 #(.SLICES(SLICES), .WIDTH(WIDTH), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_tag(in_tag), .target(target), .target_mask(target_mask), .clear(clear),
    .hit_valid(hit_valid), .hit_tag(hit_tag), .hit_ready(hit_ready), .hit_count(hit_count),
    .err_frame(err_frame), .err_ovf(err_ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level reference model.
  typedef struct { int due; logic [31:0] tag; bit match; } pend_t;
  logic [31:0] m_fifo[$];
  pend_t       m_pend[$];
  logic [19:0] m_sl[$];
  logic [31:0] m_ftag, m_cnt;
  bit          m_drop, m_ef, m_eo;
  int          m_cyc;

  typedef struct {
    logic [31:0]      tag;
    logic [4:0][19:0] sl;
    logic [95:0]      target;
    logic [95:0]      mask;
    int               last_pos;
    bit               exp_hit;
    logic [31:0]      exp_cnt;
    bit               exp_ef;
  } vec_t;
  vec_t tbl[5];

  logic [4:0][19:0] base;
  logic [99:0]      tgt100;
  logic [95:0]      asm_v;
  int               pos;

  function automatic logic [95:0] assemble(input logic [19:0] s[$]);
    logic [99:0] v;
    v = '0;
    for (int i = 0; i < s.size(); i++) v = v + (100'(s[i]) << (20 * i));
    return v[95:0];
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    pend_t       p;
    bit          push;
    logic [31:0] ptag;
    if (!rst_n) begin
      m_fifo.delete(); m_pend.delete(); m_sl.delete();
      m_drop = 0; m_cyc = 0; m_cnt = '0; m_ef = 0; m_eo = 0;
      return;
    end
    m_cyc++;
    if (hit_ready && m_fifo.size() > 0) void'(m_fifo.pop_front());
    push = 0;
    ptag = '0;
    if (m_pend.size() > 0 && m_pend[0].due == m_cyc) begin
      p = m_pend.pop_front();
      push = p.match;
      ptag = p.tag;
    end
    if (clear) begin
      m_cnt = '0; m_ef = 0; m_eo = 0;
    end
    if (push) begin
      if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (m_fifo.size() < DEPTH) m_fifo.push_back(ptag);
      else m_eo = 1;
    end
    if (in_valid) begin
      if (m_drop) begin
        if (in_last) m_drop = 0;
      end else begin
        if (m_sl.size() == 0) m_ftag = in_tag;
        m_sl.push_back(in_data);
        if (in_last) begin
          if (m_sl.size() == SLICES) begin
            p.due   = m_cyc + 2;
            p.tag   = m_ftag;
            p.match = ((assemble(m_sl) ^ target) & target_mask) == '0;
            m_pend.push_back(p);
          end else begin
            m_ef = 1;
          end
          m_sl.delete();
        end else if (m_sl.size() == SLICES) begin
          m_ef = 1;
          m_drop = 1;
          m_sl.delete();
        end
      end
    end
  endtask

  task automatic check_model();
    chk1("m_hit_valid", hit_valid, m_fifo.size() != 0);
    if (m_fifo.size() != 0) chk32("m_hit_tag", hit_tag, m_fifo[0]);
    chk32("m_hit_count", hit_count, m_cnt);
    chk1("m_err_frame", err_frame, m_ef);
    chk1("m_err_ovf", err_ovf, m_eo);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic slice(input logic [19:0] d, input bit last, input logic [31:0] tag);
    in_valid = 1'b1; in_data = d; in_last = last; in_tag = tag;
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic frame(input logic [31:0] tag, input logic [4:0][19:0] sl, input int last_pos);
    for (int s = 0; s <= last_pos; s++) slice(sl[s], s == last_pos, tag);
  endtask

  task automatic check_reset_values(input string name);
    chk1({name, "_valid"}, hit_valid, 1'b0);
    chk32({name, "_tag"}, hit_tag, 32'h0);
    chk32({name, "_count"}, hit_count, 32'h0);
    chk1({name, "_err_frame"}, err_frame, 1'b0);
    chk1({name, "_err_ovf"}, err_ovf, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_tag = '0;
    target = '0; target_mask = '0; clear = 1'b0; hit_ready = 1'b1;
    base  = {20'h00005, 20'h00004, 20'h00003, 20'h00002, 20'h00001};
    tgt100 = base;
    asm_v = tgt100[95:0];
    tbl[0] = '{32'hCAFE0001, base, asm_v,            {96{1'b1}}, 4, 1'b1, 32'd1, 1'b0};
    tbl[1] = '{32'hCAFE0002, base, asm_v ^ 96'h1,    {96{1'b1}}, 4, 1'b0, 32'd1, 1'b0};
    tbl[2] = '{32'hCAFE0003, base, asm_v ^ 96'h1,    ~96'h1,     4, 1'b1, 32'd2, 1'b0};
    tbl[3] = '{32'h00000003, base, asm_v,            {96{1'b1}}, 2, 1'b0, 32'd2, 1'b1};
    tbl[4] = '{32'h00000004, base, asm_v,            {96{1'b1}}, 4, 1'b1, 32'd3, 1'b1};

    repeat (3) step();
    rst_n = 1'b1;
    check_reset_values("reset");

    // Vector table: one frame per row, hit observed two edges after the last slice.
    foreach (tbl[i]) begin
      target = tbl[i].target;
      target_mask = tbl[i].mask;
      frame(tbl[i].tag, tbl[i].sl, tbl[i].last_pos);
      step();
      chk1("tbl_latency", hit_valid, 1'b0);
      step();
      chk1("tbl_hit", hit_valid, tbl[i].exp_hit);
      if (tbl[i].exp_hit) chk32("tbl_tag", hit_tag, tbl[i].tag);
      chk32("tbl_count", hit_count, tbl[i].exp_cnt);
      chk1("tbl_err_frame", err_frame, tbl[i].exp_ef);
      step();
    end

    // Missing last: six slices without in_last, DROP until a last slice.
    clear = 1'b1; step(); clear = 1'b0;
    target_mask = '0;
    for (int k = 0; k < 6; k++) slice(20'($urandom), 1'b0, 32'h7);
    slice(20'h0, 1'b1, 32'h7);
    chk1("drop_err", err_frame, 1'b1);
    step(); step();
    chk1("drop_nohit", hit_valid, 1'b0);
    frame(32'h2, base, 4);
    step(); step();
    chk1("after_drop_hit", hit_valid, 1'b1);
    chk32("after_drop_tag", hit_tag, 32'h2);
    step();

    // Overflow with hit_ready low, then push and pop together on a full FIFO.
    hit_ready = 1'b0;
    clear = 1'b1; step(); clear = 1'b0;
    frame(32'hB1, base, 4);
    frame(32'hB2, base, 4);
    frame(32'hB3, base, 4);
    step(); step();
    chk32("ovf_count", hit_count, 32'd3);
    chk1("ovf_flag", err_ovf, 1'b1);
    chk32("ovf_head", hit_tag, 32'hB1);
    clear = 1'b1; step(); clear = 1'b0;
    frame(32'hB4, base, 4);
    step();
    hit_ready = 1'b1; step(); hit_ready = 1'b0;
    chk1("fullpp_no_ovf", err_ovf, 1'b0);
    chk32("fullpp_head", hit_tag, 32'hB2);
    chk32("fullpp_count", hit_count, 32'd1);
    hit_ready = 1'b1; step();
    chk32("fullpp_second", hit_tag, 32'hB4);
    step();
    chk1("fullpp_drained", hit_valid, 1'b0);

    // Reset in mid-frame with a hit queued.
    hit_ready = 1'b0;
    frame(32'hA1, base, 4);
    step(); step();
    chk1("pre_reset_queued", hit_valid, 1'b1);
    slice(base[0], 1'b0, 32'hC2);
    slice(base[1], 1'b0, 32'hC2);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    step();
    rst_n = 1'b1;
    hit_ready = 1'b1;
    target = asm_v; target_mask = {96{1'b1}};
    frame(32'hC3, base, 4);
    step(); step();
    chk1("post_reset_hit", hit_valid, 1'b1);
    chk32("post_reset_tag", hit_tag, 32'hC3);
    chk32("post_reset_count", hit_count, 32'd1);
    target_mask = '0;
    for (int k = 0; k < 6; k++) frame(32'hD0 + 32'(k), base, 4);
    step(); step();
    chk32("count_seven", hit_count, 32'd7);
    frame(32'hD8, base, 4);
    step();
    clear = 1'b1; step(); clear = 1'b0;
    chk32("clear_with_match", hit_count, 32'd1);
    chk1("clear_err_frame", err_frame, 1'b0);

    // Randomized traffic against the model.
    for (int ph = 0; ph < 3; ph++) begin
      in_valid = 1'b0; clear = 1'b0;
      repeat (4) step();
      target = {$urandom, $urandom, $urandom};
      target_mask = (ph == 0) ? {96{1'b1}} : (ph == 1) ? {$urandom, $urandom, $urandom} : 96'h0;
      tgt100 = {4'($urandom), target};
      for (int c = 0; c < 1000; c++) begin
        pos = m_sl.size();
        in_valid = ($urandom_range(0, 3) != 0);
        in_data = ($urandom_range(0, 4) != 0 && pos < SLICES) ? tgt100[20*pos +: 20] : 20'($urandom);
        if (m_drop) in_last = ($urandom_range(0, 2) == 0);
        else if (pos == SLICES - 1) in_last = ($urandom_range(0, 15) != 0);
        else in_last = ($urandom_range(0, 40) == 0);
        in_tag = $urandom;
        hit_ready = ($urandom_range(0, 2) != 0);
        clear = ($urandom_range(0, 60) == 0);
        step();
      end
    end
    in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
